// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and lane helpers for the memory-access stage
package mem_pkg;

   // Access size encodings as carried on ex_size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Default abort limit for an unanswered request
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Byte enables for a little-endian access of the given size at the given lane
   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: lane_be = 4'b0001 << lane;
         SZ_HALF: lane_be = lane[1] ? 4'b1100 : 4'b0011;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   // Replicate store data so every lane carries it; byte enables pick the right one
   function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: lane_wdata = {4{wdata[7:0]}};
         SZ_HALF: lane_wdata = {2{wdata[15:0]}};
         default: lane_wdata = wdata;
      endcase
   endfunction

   // Half must be even, word must be 4-aligned, size 11 is never legal
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      is_misaligned = ((size == SZ_HALF) && lane[0])
                   || ((size == SZ_WORD) && (lane != 2'b00))
                   || (size == SZ_ILL);
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - load data lane select with sign/zero extension
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {addr_i, 3'b000};

   // Mask to the access width and extend from its top bit when signed
   always_comb begin
      result_o = shifted;
      case (size_i)
         SZ_BYTE: result_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         SZ_HALF: result_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         default: result_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory handshake, alignment, stall
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_load,
   input  logic        ex_store,
   input  logic [1:0]  ex_size,
   input  logic        ex_signed,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [31:0] ex_result,
   input  logic        ex_IP_write,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic [31:0] wb_data,
   output logic        wb_IP_write,
   output logic        mem_stall,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [1:0]        lane_q, lane_d;
   logic              ipw_q, ipw_d;
   logic              mis_q, mis_d;
   logic              berr_q, berr_d;

   logic              memop;
   logic              misaligned;
   logic [31:0]       load_data;

   assign memop      = ex_valid & (ex_load | ex_store);
   assign misaligned = is_misaligned(ex_size, ex_addr[1:0]);

   mem_load_align u_align (
      .rdata_i  (dm_rdata),
      .addr_i   (lane_q),
      .size_i   (size_q),
      .signed_i (sgn_q),
      .result_o (load_data)
   );

   // State and access-latch register; reset abandons any outstanding request
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         size_q  <= SZ_BYTE;
         sgn_q   <= 1'b0;
         lane_q  <= 2'b00;
         ipw_q   <= 1'b0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         lane_q  <= lane_d;
         ipw_q   <= ipw_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end

   // Next state, request latching and the writeback/stall outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      we_d        = we_q;
      be_d        = be_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      sgn_d       = sgn_q;
      lane_d      = lane_q;
      ipw_d       = ipw_q;
      mis_d       = 1'b0;
      berr_d      = 1'b0;
      wb_data     = ex_result;
      wb_IP_write = 1'b0;
      mem_stall   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!memop) begin
               wb_IP_write = ex_valid & ex_IP_write;
            end else if (misaligned) begin
               mis_d = 1'b1;
            end else begin
               mem_stall = 1'b1;
               state_d   = ST_BUSY;
               cnt_d     = '0;
               req_d     = 1'b1;
               we_d      = ex_store;
               be_d      = lane_be(ex_size, ex_addr[1:0]);
               addr_d    = {ex_addr[31:2], 2'b00};
               wdata_d   = lane_wdata(ex_size, ex_wdata);
               size_d    = ex_size;
               sgn_d     = ex_signed;
               lane_d    = ex_addr[1:0];
               ipw_d     = ex_IP_write;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (dm_ack) begin
               // Ack beats a coincident timeout
               if (!we_q) begin
                  wb_data     = load_data;
                  wb_IP_write = ipw_q;
               end
               state_d = ST_IDLE;
               req_d   = 1'b0;
            end else if (cnt_q == TO_CNT) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               berr_d  = 1'b1;
            end else begin
               mem_stall = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rst) begin
         mem_stall   = 1'b0;
         wb_IP_write = 1'b0;
      end
   end

   assign dm_req       = req_q;
   assign dm_we        = we_q;
   assign dm_be        = be_q;
   assign dm_addr      = addr_q;
   assign dm_wdata     = wdata_q;
   assign misalign_err = mis_q;
   assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_load, ex_store, ex_signed, ex_IP_write;
   logic [1:0]  ex_size;
   logic [31:0] ex_addr, ex_wdata, ex_result;
   logic        dm_req, dm_we, dm_ack;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [31:0] wb_data;
   logic        wb_IP_write, mem_stall, misalign_err, bus_err;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(15), .CNT_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid     (ex_valid),
      .ex_load      (ex_load),
      .ex_store     (ex_store),
      .ex_size      (ex_size),
      .ex_signed    (ex_signed),
      .ex_addr      (ex_addr),
      .ex_wdata     (ex_wdata),
      .ex_result    (ex_result),
      .ex_IP_write  (ex_IP_write),
      .dm_req       (dm_req),
      .dm_we        (dm_we),
      .dm_be        (dm_be),
      .dm_addr      (dm_addr),
      .dm_wdata     (dm_wdata),
      .dm_rdata     (dm_rdata),
      .dm_ack       (dm_ack),
      .wb_data      (wb_data),
      .wb_IP_write  (wb_IP_write),
      .mem_stall    (mem_stall),
      .misalign_err (misalign_err),
      .bus_err      (bus_err)
   );

   typedef struct {
      string       name;
      logic        valid;
      logic        load;
      logic        store;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] result;
      logic        ipw;
      logic [31:0] exp_data;
      logic        exp_ipw;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic set_ex(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] res, input logic ipw);
      ex_valid = v; ex_load = ld; ex_store = st; ex_size = sz; ex_signed = sg;
      ex_addr = a; ex_wdata = wd; ex_result = res; ex_IP_write = ipw;
   endtask

   // One aligned access, acked in BUSY cycle ack_cyc; reports what the DUT showed
   task automatic mem_op(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int ack_cyc,
                         input logic [31:0] rdata,
                         output logic [31:0] wbd, output logic wbip, output int stalls,
                         output logic [3:0] be, output logic [31:0] wdo, output logic we,
                         output logic [31:0] ao, output logic req_b, output logic req_after);
      @(negedge clk);
      set_ex(1'b1, ~st, st, sz, sg, a, wd, 32'h0BAD_0BAD, 1'b1);
      dm_ack = 1'b0;
      #1;
      stalls = mem_stall ? 1 : 0;
      for (int c = 1; c <= ack_cyc; c++) begin
         @(negedge clk);
         if (c == ack_cyc) begin
            dm_ack   = 1'b1;
            dm_rdata = rdata;
         end
         #1;
         if (c == 1) begin
            be = dm_be; wdo = dm_wdata; we = dm_we; ao = dm_addr; req_b = dm_req;
         end
         if (mem_stall) stalls++;
         if (c == ack_cyc) begin
            wbd  = wb_data;
            wbip = wb_IP_write;
         end
      end
      @(negedge clk);
      dm_ack   = 1'b0;
      ex_valid = 1'b0;
      #1;
      req_after = dm_req;
   endtask

   logic [31:0] r_wbd, r_wdo, r_ao;
   logic        r_wbip, r_we, r_reqb, r_reqa;
   logic [3:0]  r_be;
   int          r_stalls;
   int          rel_cyc;

   initial begin
      vecs[0] = '{"alu_pass",       1'b1, 1'b0, 1'b0, 2'b10, 32'h0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
      vecs[1] = '{"alu_nowrite",    1'b1, 1'b0, 1'b0, 2'b10, 32'h0,   32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0};
      vecs[2] = '{"bubble_load",    1'b0, 1'b1, 1'b0, 2'b10, 32'h100, 32'h1111_2222, 1'b1, 32'h1111_2222, 1'b0, 1'b0};
      vecs[3] = '{"mis_word_101",   1'b1, 1'b1, 1'b0, 2'b10, 32'h101, 32'h0000_0101, 1'b1, 32'h0000_0101, 1'b0, 1'b1};
      vecs[4] = '{"mis_half_103",   1'b1, 1'b1, 1'b0, 2'b01, 32'h103, 32'h0000_0103, 1'b1, 32'h0000_0103, 1'b0, 1'b1};
      vecs[5] = '{"illegal_size",   1'b1, 1'b1, 1'b0, 2'b11, 32'h100, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, 1'b1};
      vecs[6] = '{"mis_store_102",  1'b1, 1'b0, 1'b1, 2'b10, 32'h102, 32'h0000_0102, 1'b0, 32'h0000_0102, 1'b0, 1'b1};
      vecs[7] = '{"alu_zero",       1'b1, 1'b0, 1'b0, 2'b00, 32'h0,   32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

      // Reset state, with a writing ALU op presented to prove the reset gating
      rst = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
      set_ex(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h5555_AAAA, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_dm_req",   {31'h0, dm_req},       32'h0);
      chk("rst_dm_we",    {31'h0, dm_we},        32'h0);
      chk("rst_dm_be",    {28'h0, dm_be},        32'h0);
      chk("rst_dm_addr",  dm_addr,               32'h0);
      chk("rst_dm_wdata", dm_wdata,              32'h0);
      chk("rst_mis",      {31'h0, misalign_err}, 32'h0);
      chk("rst_berr",     {31'h0, bus_err},      32'h0);
      chk("rst_stall",    {31'h0, mem_stall},    32'h0);
      chk("rst_wbip",     {31'h0, wb_IP_write},  32'h0);
      rst = 1'b1;

      // Non-stalling vectors from IDLE
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         set_ex(vecs[i].valid, vecs[i].load, vecs[i].store, vecs[i].size, 1'b0,
                vecs[i].addr, 32'h0, vecs[i].result, vecs[i].ipw);
         #1;
         chk({vecs[i].name, "_wbdata"}, wb_data,                 vecs[i].exp_data);
         chk({vecs[i].name, "_wbip"},   {31'h0, wb_IP_write},    {31'h0, vecs[i].exp_ipw});
         chk({vecs[i].name, "_stall"},  {31'h0, mem_stall},      32'h0);
         chk({vecs[i].name, "_req"},    {31'h0, dm_req},         32'h0);
         @(posedge clk); #1;
         chk({vecs[i].name, "_mis"},    {31'h0, misalign_err},   {31'h0, vecs[i].exp_mis});
      end

      // Ack arriving while IDLE must not disturb the pass-through
      @(negedge clk);
      set_ex(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h7777_0001, 1'b1);
      dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
      #1;
      chk("idle_ack_wbdata", wb_data, 32'h7777_0001);
      @(negedge clk);
      dm_ack = 1'b0;
      #1;
      chk("idle_ack_req", {31'h0, dm_req}, 32'h0);

      // Word load, ack in third BUSY cycle
      mem_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF,
             r_wbd, r_wbip, r_stalls, r_be, r_wdo, r_we, r_ao, r_reqb, r_reqa);
      chk("wload_stalls", r_stalls,              32'd3);
      chk("wload_wbdata", r_wbd,                 32'hDEAD_BEEF);
      chk("wload_wbip",   {31'h0, r_wbip},       32'h1);
      chk("wload_be",     {28'h0, r_be},         32'hF);
      chk("wload_addr",   r_ao,                  32'h100);
      chk("wload_we",     {31'h0, r_we},         32'h0);
      chk("wload_reqb",   {31'h0, r_reqb},       32'h1);
      chk("wload_reqa",   {31'h0, r_reqa},       32'h0);

      // Signed and unsigned byte loads at lane 3, minimum latency
      mem_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h8012_3456,
             r_wbd, r_wbip, r_stalls, r_be, r_wdo, r_we, r_ao, r_reqb, r_reqa);
      chk("sbyte_wbdata", r_wbd,          32'hFFFF_FF80);
      chk("sbyte_stalls", r_stalls,       32'd1);
      chk("sbyte_be",     {28'h0, r_be},  32'h8);
      chk("sbyte_addr",   r_ao,           32'h100);
      mem_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1, 32'h8012_3456,
             r_wbd, r_wbip, r_stalls, r_be, r_wdo, r_we, r_ao, r_reqb, r_reqa);
      chk("ubyte_wbdata", r_wbd, 32'h0000_0080);

      // Signed half load from upper half
      mem_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 2, 32'h8001_7FFF,
             r_wbd, r_wbip, r_stalls, r_be, r_wdo, r_we, r_ao, r_reqb, r_reqa);
      chk("shalf_wbdata", r_wbd,         32'hFFFF_8001);
      chk("shalf_be",     {28'h0, r_be}, 32'hC);

      // Half store at 0x202
      mem_op(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 1, 32'h0,
             r_wbd, r_wbip, r_stalls, r_be, r_wdo, r_we, r_ao, r_reqb, r_reqa);
      chk("hstore_be",    {28'h0, r_be},   32'hC);
      chk("hstore_wdata", r_wdo,           32'hABCD_ABCD);
      chk("hstore_we",    {31'h0, r_we},   32'h1);
      chk("hstore_addr",  r_ao,            32'h200);
      chk("hstore_wbip",  {31'h0, r_wbip}, 32'h0);

      // Byte store at lane 1
      mem_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_565A, 1, 32'h0,
             r_wbd, r_wbip, r_stalls, r_be, r_wdo, r_we, r_ao, r_reqb, r_reqa);
      chk("bstore_be",    {28'h0, r_be}, 32'h2);
      chk("bstore_wdata", r_wdo,         32'h5A5A_5A5A);

      // Timeout: no ack ever
      @(negedge clk);
      set_ex(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1);
      dm_ack = 1'b0;
      #1;
      chk("to_accept_stall", {31'h0, mem_stall}, 32'h1);
      rel_cyc = -1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk); #1;
         if (!mem_stall) begin
            rel_cyc = c;
            chk("to_release_wbip", {31'h0, wb_IP_write}, 32'h0);
            chk("to_release_req",  {31'h0, dm_req},      32'h1);
            break;
         end
      end
      chk("to_release_cycle", rel_cyc, 32'd16);
      @(negedge clk);
      ex_valid = 1'b0;
      #1;
      chk("to_bus_err",   {31'h0, bus_err}, 32'h1);
      chk("to_req_drop",  {31'h0, dm_req},  32'h0);
      @(negedge clk); #1;
      chk("to_bus_err_pulse", {31'h0, bus_err}, 32'h0);

      // Reset mid-BUSY on a fresh access
      @(negedge clk);
      set_ex(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      chk("mid_busy_req", {31'h0, dm_req}, 32'h1);
      @(negedge clk);
      rst = 1'b0;
      ex_valid = 1'b0;
      #1;
      chk("mid_rst_stall", {31'h0, mem_stall}, 32'h0);
      @(posedge clk); #1;
      chk("mid_rst_req", {31'h0, dm_req}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      set_ex(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h2468_ACE0, 1'b1);
      dm_ack = 1'b1; dm_rdata = 32'h1357_9BDF;
      #1;
      chk("post_rst_wbdata", wb_data,              32'h2468_ACE0);
      chk("post_rst_stall",  {31'h0, mem_stall},   32'h0);
      @(negedge clk);
      dm_ack = 1'b0;
      ex_valid = 1'b0;
      #1;
      chk("post_rst_req",    {31'h0, dm_req},      32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage that sits directly upstream of the MEM/WB pipeline register.
- Takes the EX-stage result and load/store request, runs a req/ack transaction to data memory, and aligns the data (lane select plus sign/zero extend).
- Presents the writeback data and write-enable to the MEM/WB register.
- Generates the pipeline stall that holds both the EX/MEM and MEM/WB registers while a memory access is outstanding.

Parameters:
- TIMEOUT, 15: max cycles dm_req may stay high without dm_ack before the access is aborted.
- CNT_W, 4: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-low.
- ex_valid  in  1  EX/MEM register holds a valid instruction.
- ex_load  in  1  instruction is a load.
- ex_store  in  1  instruction is a store; ex_load and ex_store are never both 1.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- ex_signed  in  1  sign-extend load data (1) or zero-extend (0).
- ex_addr  in  32  byte address (ALU result for memory ops).
- ex_wdata  in  32  store data (rs2 value).
- ex_result  in  32  ALU result for non-memory ops.
- ex_IP_write  in  1  instruction writes the register file.
- dm_req  out  1  data-memory request; registered.
- dm_we  out  1  write (1) or read (0); registered.
- dm_be  out  4  byte enables; registered.
- dm_addr  out  32  word-aligned address, {ex_addr[31:2],2'b00}; registered.
- dm_wdata  out  32  lane-replicated store data; registered.
- dm_rdata  in  32  read data, valid in the dm_ack cycle.
- dm_ack  in  1  one-cycle completion pulse.
- wb_data  out  32  data to MEM/WB data_in.
- wb_IP_write  out  1  to MEM/WB IP_write_in.
- mem_stall  out  1  hold; drives MEM/WB dataena and the EX/MEM hold.
- misalign_err  out  1  one-cycle pulse on a misaligned or illegal access.
- bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, counter 0, dm_req/dm_we/dm_be/dm_addr/dm_wdata/misalign_err/bus_err = 0. While rst=0, mem_stall=0 and wb_IP_write=0.
- memop = ex_valid & (ex_load | ex_store).
- misaligned = (size 01 & addr[0]) | (size 10 & addr[1:0]!=0) | size 11.
- FSM states: IDLE, BUSY.
- IDLE, no memop:
  - wb_data = ex_result; wb_IP_write = ex_valid & ex_IP_write; mem_stall = 0.
  - Zero-latency pass-through.
- IDLE, memop & misaligned:
  - No request issued; misalign_err pulses next cycle.
  - wb_IP_write = 0, wb_data = ex_result, mem_stall = 0.
- IDLE, memop & aligned:
  - mem_stall = 1 combinationally.
  - At posedge: go to BUSY; latch dm_req=1, dm_we=ex_store, dm_be, dm_addr, dm_wdata, ex_size, ex_signed, addr[1:0], ex_IP_write; counter cleared.
- BUSY: dm_req held at 1; counter increments each cycle.
  - dm_ack=0 and counter<TIMEOUT: mem_stall = 1.
  - dm_ack=1 (same cycle): mem_stall = 0.
    - Load: wb_data = aligned dm_rdata; wb_IP_write = latched IP_write.
    - Store: wb_IP_write = 0.
    - At posedge: dm_req=0, go to IDLE.
  - counter==TIMEOUT and dm_ack=0: mem_stall = 0, wb_IP_write = 0; at posedge dm_req=0, bus_err pulses 1 cycle, go to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- Store lanes (little-endian):
  - Byte: wdata = {4{b}}, be = 4'b0001 << addr[1:0].
  - Half: wdata = {2{h}}, be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
- Load align: shift dm_rdata right by 8*addr[1:0], then mask to 8/16 bits and sign/zero extend to 32.
- dm_ack while IDLE is ignored.
- Reset mid-BUSY drops dm_req at that edge; any later ack is ignored.
- Minimum memory latency: 1 stall cycle (ack in the first BUSY cycle).

Decomposition:
- Package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - state encodings ST_IDLE/ST_BUSY;
  - TIMEOUT default.
- One combinational sub-module, mem_load_align: inputs rdata, addr[1:0], size, signed; output 32-bit result.

Test Plan:
- ALU op, ex_result=0x1234_5678, ex_IP_write=1 -> same cycle wb_data=0x1234_5678, wb_IP_write=1, mem_stall=0, dm_req stays 0.
- Word load addr 0x100, dm_rdata=0xDEAD_BEEF, ack in the 3rd BUSY cycle:
  - mem_stall high for 3 cycles (accept + 2 BUSY), low in the ack cycle;
  - wb_data=0xDEAD_BEEF.
- Signed byte load addr 0x103, rdata=0x80xx_xxxx -> wb_data=0xFFFF_FF80; with ex_signed=0 -> 0x0000_0080.
- Half store addr 0x202, wdata=0x0000_ABCD -> dm_be=1100, dm_wdata=0xABCD_ABCD, dm_we=1, wb_IP_write=0.
- Word load addr 0x101 -> no dm_req, misalign_err pulse, wb_IP_write=0, mem_stall=0.
- Load with dm_ack never asserted -> stall released after 15 BUSY cycles, bus_err pulse, dm_req=0; then rst=0 mid-BUSY on a new access -> dm_req=0 and IDLE next edge.
